// File: rtl/pulse_event_packer_if.sv
// Interface: pulse_event_packer_if
// Bundles the pulse input, flush request and the record valid/ready channel of
// pulse_event_packer.
//   pulse_in   producer -> packer   synchronized pulse, one event per high cycle
//   flush      producer -> packer   close the open record
//   out_ready  consumer -> packer   consumer accepts the record
//   out_valid  packer -> consumer   record available
//   out_count  packer -> consumer   events in the record
//   drop_cnt   packer -> consumer   sticky, saturating count of lost pulses
// The master modport is the producer/consumer side; the slave modport is the packer.
interface pulse_event_packer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             pulse_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output pulse_in,
    output flush,
    output out_ready,
    input  out_valid,
    input  out_count,
    input  drop_cnt
  );

  modport slave (
    input  pulse_in,
    input  flush,
    input  out_ready,
    output out_valid,
    output out_count,
    output drop_cnt
  );
endinterface

// File: rtl/pulse_event_packer.sv
// Module: pulse_event_packer
// Counts single-cycle synchronized pulses in the destination clock domain and
// packs them into count records. A record closes when its window expires
// (WIN_CYC cycles measured from the first pulse), when it reaches MAX_EVT
// events, or on flush. Closed records are offered over valid/ready; pulses that
// arrive while a record waits are buffered (up to MAX_EVT) and the rest are
// tallied in a saturating drop counter.
// Ports:
//   des_clk   destination-domain clock
//   des_rst   asynchronous, active-high reset
//   bus       pulse_event_packer_if slave: pulse_in, flush, out_ready in;
//             out_valid, out_count, drop_cnt out
// Parameters:
//   CNT_W     width of out_count / drop_cnt; MAX_EVT must fit in CNT_W bits
//   WIN_CYC   window length in cycles (>= 2)
//   MAX_EVT   event count that closes a record early (>= 1)
module pulse_event_packer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned WIN_CYC = 64,
  parameter int unsigned MAX_EVT = 16
) (
  input logic                 des_clk,
  input logic                 des_rst,
  pulse_event_packer_if.slave bus
);

  // Timer holds the offset of the current edge from the window-opening edge,
  // so it only needs to reach WIN_CYC-1.
  localparam int unsigned TIMER_W = $clog2(WIN_CYC);

  localparam logic [CNT_W-1:0]   MaxEvt    = CNT_W'(MAX_EVT);
  localparam logic [CNT_W-1:0]   AccOne    = CNT_W'(1);
  localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(WIN_CYC - 1);
  localparam logic [TIMER_W-1:0] TimerOne  = TIMER_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StOutput
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic               acc_full;
  logic               pulse_drop;
  logic [CNT_W-1:0]   acc_n;
  logic               handshake;
  logic               close_rec;

  // A full accumulator turns any further pulse into a drop; otherwise the pulse
  // is counted. acc_q is 0 in StIdle, so this is only ever true in StAccum
  // (entered full from a handshake) or StOutput.
  assign acc_full   = (acc_q == MaxEvt);
  assign pulse_drop = bus.pulse_in & acc_full;
  assign acc_n      = acc_q + {{(CNT_W-1){1'b0}}, bus.pulse_in & ~acc_full};
  assign handshake  = valid_q & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    timer_d   = timer_q;
    count_d   = count_q;
    valid_d   = valid_q;
    close_rec = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Flush is ignored here: empty records are never emitted.
        if (bus.pulse_in) begin
          state_d = StAccum;
          acc_d   = AccOne;
          timer_d = TimerOne;
        end
      end

      StAccum: begin
        close_rec = (timer_q == TimerLast) || (acc_n >= MaxEvt) || bus.flush;
        if (close_rec) begin
          // The pulse sampled at the closing edge belongs to this record.
          count_d = acc_n;
          valid_d = 1'b1;
          acc_d   = '0;
          timer_d = '0;
          state_d = StOutput;
        end else begin
          acc_d   = acc_n;
          timer_d = timer_q + TimerOne;
        end
      end

      StOutput: begin
        // Keep buffering while the record waits; flush has no effect.
        acc_d = acc_n;
        if (handshake) begin
          valid_d = 1'b0;
          if (acc_n == '0) begin
            state_d = StIdle;
          end else begin
            // Buffered pulses start a new window at the handshake edge.
            state_d = StAccum;
            timer_d = TimerOne;
          end
        end
      end

      default: begin
        state_d = StIdle;
        acc_d   = '0;
        timer_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Sticky drop tally, held at all-ones once saturated.
  always_comb begin
    drop_d = drop_q;
    if (pulse_drop && (drop_q != '1)) begin
      drop_d = drop_q + AccOne;
    end
  end

  always_ff @(posedge des_clk or posedge des_rst) begin
    if (des_rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      timer_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      timer_q <= timer_d;
      count_q <= count_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_count = count_q;
  assign bus.drop_cnt  = drop_q;

  // A stalled record must stay put until the consumer takes it.
  a_hold_record : assert property (@(posedge des_clk) disable iff (des_rst)
    (valid_q && !bus.out_ready) |=> (valid_q && $stable(count_q)));

  a_acc_bounded : assert property (@(posedge des_clk) disable iff (des_rst)
    (acc_q <= MaxEvt) && (count_q <= MaxEvt));

endmodule

// File: tb/tb_pulse_event_packer.sv
module tb_pulse_event_packer;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned WIN_CYC = 64;
  localparam int unsigned MAX_EVT = 16;
  localparam int unsigned DROP_MAX = (1 << CNT_W) - 1;

  logic des_clk = 1'b0;
  logic des_rst = 1'b0;

  pulse_event_packer_if #(.CNT_W(CNT_W)) bus ();

  pulse_event_packer #(
    .CNT_W  (CNT_W),
    .WIN_CYC(WIN_CYC),
    .MAX_EVT(MAX_EVT)
  ) dut (
    .des_clk(des_clk),
    .des_rst(des_rst),
    .bus    (bus)
  );

  always #5 des_clk = ~des_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: an open record is described by the edge number where its
  // window started and how many events it holds; a pending record by its count.
  int cyc;
  bit m_open;
  bit m_pend;
  int m_start;
  int m_acc;
  int m_cnt;
  int m_drops;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_open = 0; m_pend = 0; m_start = 0; m_acc = 0; m_cnt = 0; m_drops = 0;
  endtask

  task automatic add_event();
    if (m_acc < MAX_EVT) m_acc++;
    else if (m_drops < DROP_MAX) m_drops++;
  endtask

  task automatic model_step(input bit p, input bit f, input bit r);
    if (m_pend) begin
      if (p) add_event();
      if (r) begin
        m_pend = 0;
        m_open = (m_acc > 0);
        m_start = cyc;
      end
    end else if (m_open) begin
      if (p) add_event();
      if ((cyc - m_start == WIN_CYC - 1) || (m_acc >= MAX_EVT) || f) begin
        m_pend = 1;
        m_cnt = m_acc;
        m_acc = 0;
        m_open = 0;
      end
    end else if (p) begin
      m_open = 1;
      m_start = cyc;
      m_acc = 1;
    end
    cyc++;
  endtask

  // One edge: apply inputs, advance the model, sample 1 time unit after the edge.
  task automatic drive(input bit p, input bit f, input bit r);
    bus.pulse_in = p;
    bus.flush = f;
    bus.out_ready = r;
    model_step(p, f, r);
    @(posedge des_clk);
    #1;
    check_eq("valid", bus.out_valid, m_pend);
    if (m_pend) check_eq("count", bus.out_count, m_cnt);
    check_eq("drops", bus.drop_cnt, m_drops);
  endtask

  task automatic run_idle(input int n, input bit r);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, r);
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic do_reset();
    bus.pulse_in = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    des_rst = 1'b1;
    #1;
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_count", bus.out_count, 0);
    check_eq("rst_drops", bus.drop_cnt, 0);
    @(posedge des_clk);
    #1;
    des_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single pulse at edge 10 is emitted after edge 73.
    run_idle(10, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    run_idle(62, 1'b1);
    check_eq("t1_early", bus.out_valid, 0);
    drive(1'b0, 1'b0, 1'b1);
    check_eq("t1_valid", bus.out_valid, 1);
    check_eq("t1_count", bus.out_count, 1);
    drive(1'b0, 1'b0, 1'b1);
    check_eq("t1_idle", bus.out_valid, 0);

    // Threshold close on 16 back-to-back pulses.
    do_reset();
    run_idle(5, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b1);
    check_eq("t2_valid", bus.out_valid, 1);
    check_eq("t2_count", bus.out_count, 16);
    check_eq("t2_drops", bus.drop_cnt, 0);
    run_idle(3, 1'b1);

    // Window boundary: pulses at 0, 30, 63 share a record; 64 opens a new one.
    do_reset();
    drive(1'b1, 1'b0, 1'b1);
    run_idle(29, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    run_idle(32, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    check_eq("t3_valid", bus.out_valid, 1);
    check_eq("t3_count", bus.out_count, 3);
    drive(1'b1, 1'b0, 1'b1);
    check_eq("t3_accepted", bus.out_valid, 0);
    run_idle(62, 1'b1);
    check_eq("t3_win2_early", bus.out_valid, 0);
    drive(1'b0, 1'b0, 1'b1);
    check_eq("t3_win2_count", bus.out_count, 1);
    run_idle(2, 1'b1);

    // Back-pressure: buffered pulses cap at MAX_EVT, the rest are drops.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    check_eq("t4_rec1_count", bus.out_count, 1);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0);
    check_eq("t4_rec1_held", bus.out_count, 1);
    check_eq("t4_drops", bus.drop_cnt, 4);
    drive(1'b0, 1'b0, 1'b1);
    check_eq("t4_handshake", bus.out_valid, 0);
    drive(1'b0, 1'b0, 1'b1);
    check_eq("t4_rec2_valid", bus.out_valid, 1);
    check_eq("t4_rec2_count", bus.out_count, 16);
    run_idle(2, 1'b1);

    // Flush with a coincident pulse; flush while idle emits nothing.
    do_reset();
    run_idle(2, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    run_idle(2, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    run_idle(2, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    check_eq("t5_count", bus.out_count, 4);
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1);
    check_eq("t5_idle_flush", bus.out_valid, 0);

    // Reset mid-accumulation discards acc.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1);
    do_reset();
    drive(1'b1, 1'b0, 1'b1);
    run_idle(63, 1'b1);
    check_eq("t6_accum_count", bus.out_count, 1);
    run_idle(2, 1'b1);

    // Drop counter saturation, then reset mid-output.
    do_reset();
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, 1'b0);
    check_eq("sat_drops", bus.drop_cnt, DROP_MAX);
    check_eq("sat_valid", bus.out_valid, 1);
    do_reset();
    drive(1'b1, 1'b0, 1'b1);
    run_idle(63, 1'b1);
    check_eq("t6_output_count", bus.out_count, 1);
    run_idle(2, 1'b1);

    // Randomized segments with varying pulse, flush and ready densities.
    do_reset();
    for (int seg = 0; seg < 12; seg++) begin
      int unsigned p_pct = $urandom_range(95, 5);
      int unsigned f_pct = $urandom_range(10, 0);
      int unsigned r_pct = $urandom_range(100, 0);
      if (seg == 6) do_reset();
      for (int i = 0; i < 250; i++) begin
        drive($urandom_range(99, 0) < p_pct, $urandom_range(99, 0) < f_pct,
              $urandom_range(99, 0) < r_pct);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
